// File: rtl/fp_cmp_pipe.sv
// Two-stage IEEE-754 compare / min / max unit (FEQ, FLT, FLE, FMIN, FMAX) with
// valid/ready flow control on both sides and RISC-V-F NaN and invalid-flag rules.
module fp_cmp_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int W     = 1 + EXP_W + MAN_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] read_data1,
    input  logic [W-1:0] read_data2,
    input  logic [2:0]   op,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] cmpdata_out,
    output logic         nv_flag,
    output logic         illegal_op
);

    localparam logic [2:0] OP_FEQ  = 3'd0;
    localparam logic [2:0] OP_FLT  = 3'd1;
    localparam logic [2:0] OP_FLE  = 3'd2;
    localparam logic [2:0] OP_FMIN = 3'd3;
    localparam logic [2:0] OP_FMAX = 3'd4;

    localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    typedef struct packed {
        logic nan;
        logic snan;
        logic zero;
        logic sign;
    } cls_t;

    function automatic cls_t classify(input logic [W-1:0] x);
        cls_t c;
        logic exp_ones;
        logic exp_zero;
        logic man_zero;
        exp_ones = &x[W-2 -: EXP_W];
        exp_zero = ~|x[W-2 -: EXP_W];
        man_zero = ~|x[MAN_W-1:0];
        c.nan    = exp_ones && !man_zero;
        c.snan   = c.nan && !x[MAN_W-1];
        c.zero   = exp_zero && man_zero;
        c.sign   = x[W-1];
        return c;
    endfunction

    // Stage 1 state
    logic         s1_valid_q;
    cls_t         cls_a_q, cls_b_q;
    logic         mag_lt_q, mag_eq_q;
    logic [2:0]   op_q;
    logic [W-1:0] a_q, b_q;

    // Stage 2 state
    logic         out_valid_q;
    logic [W-1:0] res_q, res_d;
    logic         nv_q, nv_d;
    logic         ill_q, ill_d;

    logic s2_adv;
    logic s1_load;

    assign s2_adv   = !out_valid_q || out_ready;
    assign in_ready = !s1_valid_q || s2_adv;
    assign s1_load  = in_valid && in_ready;

    // Ordering derived from the registered classification and magnitude compare
    logic both_zero, any_nan, any_snan;
    logic lt_cmp, eq_cmp, lt_tot;

    always_comb begin
        both_zero = cls_a_q.zero && cls_b_q.zero;
        any_nan   = cls_a_q.nan || cls_b_q.nan;
        any_snan  = cls_a_q.snan || cls_b_q.snan;
        lt_cmp    = 1'b0;
        lt_tot    = 1'b0;
        if (cls_a_q.sign != cls_b_q.sign) begin
            lt_cmp = cls_a_q.sign && !both_zero;
            lt_tot = cls_a_q.sign;
        end else if (!cls_a_q.sign) begin
            lt_cmp = mag_lt_q;
            lt_tot = mag_lt_q;
        end else begin
            lt_cmp = !mag_lt_q && !mag_eq_q;
            lt_tot = !mag_lt_q && !mag_eq_q;
        end
        eq_cmp = both_zero || ((cls_a_q.sign == cls_b_q.sign) && mag_eq_q);
    end

    // lt_tot orders -0 below +0, which only min/max care about
    always_comb begin
        res_d = '0;
        nv_d  = 1'b0;
        ill_d = 1'b0;
        case (op_q)
            OP_FEQ: begin
                res_d[0] = !any_nan && eq_cmp;
                nv_d     = any_snan;
            end
            OP_FLT: begin
                res_d[0] = !any_nan && lt_cmp;
                nv_d     = any_nan;
            end
            OP_FLE: begin
                res_d[0] = !any_nan && (lt_cmp || eq_cmp);
                nv_d     = any_nan;
            end
            OP_FMIN, OP_FMAX: begin
                nv_d = any_snan;
                if (cls_a_q.nan && cls_b_q.nan)
                    res_d = QNAN;
                else if (cls_a_q.nan)
                    res_d = b_q;
                else if (cls_b_q.nan)
                    res_d = a_q;
                else if (op_q == OP_FMIN)
                    res_d = lt_tot ? a_q : b_q;
                else
                    res_d = lt_tot ? b_q : a_q;
            end
            default: ill_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            cls_a_q    <= '0;
            cls_b_q    <= '0;
            mag_lt_q   <= 1'b0;
            mag_eq_q   <= 1'b0;
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
        end else begin
            if (in_ready)
                s1_valid_q <= in_valid;
            if (s1_load) begin
                cls_a_q  <= classify(read_data1);
                cls_b_q  <= classify(read_data2);
                mag_lt_q <= read_data1[W-2:0] < read_data2[W-2:0];
                mag_eq_q <= read_data1[W-2:0] == read_data2[W-2:0];
                op_q     <= op;
                a_q      <= read_data1;
                b_q      <= read_data2;
            end
        end
    end

    // Result registers only move on a real transfer so a stalled result stays put
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            res_q       <= '0;
            nv_q        <= 1'b0;
            ill_q       <= 1'b0;
        end else if (s2_adv) begin
            out_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                res_q <= res_d;
                nv_q  <= nv_d;
                ill_q <= ill_d;
            end
        end
    end

    assign out_valid   = out_valid_q;
    assign cmpdata_out = res_q;
    assign nv_flag     = nv_q;
    assign illegal_op  = ill_q;

endmodule

// File: tb/tb_fp_cmp_pipe.sv
// Bench for fp_cmp_pipe: directed vectors, backpressure, async reset and random
// traffic against an ordering-key reference model; plus a half-precision instance.
module tb_fp_cmp_pipe;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        in_valid, in_ready, out_valid, out_ready, nv_flag, illegal_op;
    logic [31:0] a, b, cmpdata_out;
    logic [2:0]  op;

    logic        h_in_valid, h_in_ready, h_out_valid, h_out_ready, h_nv, h_ill;
    logic [15:0] h_a, h_b, h_out;
    logic [2:0]  h_op;

    fp_cmp_pipe dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .read_data1(a), .read_data2(b), .op(op), .out_valid(out_valid),
        .out_ready(out_ready), .cmpdata_out(cmpdata_out), .nv_flag(nv_flag),
        .illegal_op(illegal_op)
    );

    fp_cmp_pipe #(.EXP_W(5), .MAN_W(10)) dut_h (
        .clk(clk), .rst(rst), .in_valid(h_in_valid), .in_ready(h_in_ready),
        .read_data1(h_a), .read_data2(h_b), .op(h_op), .out_valid(h_out_valid),
        .out_ready(h_out_ready), .cmpdata_out(h_out), .nv_flag(h_nv),
        .illegal_op(h_ill)
    );

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [31:0] r;
        logic        nv;
        logic        ill;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur_exp;
    exp_t mon_e;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Reference model: floats mapped onto signed integer ordering keys
    function automatic bit is_nan(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
    endfunction

    function automatic bit is_snan(input logic [31:0] x);
        return is_nan(x) && !x[22];
    endfunction

    function automatic longint okey(input logic [31:0] x);
        longint m;
        m = longint'(x[30:0]);
        return x[31] ? -m : m;
    endfunction

    function automatic longint tkey(input logic [31:0] x);
        longint m;
        m = longint'(x[30:0]);
        return x[31] ? -m - 1 : m;
    endfunction

    function automatic exp_t model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        exp_t e;
        bit an, sn;
        an = is_nan(x) || is_nan(y);
        sn = is_snan(x) || is_snan(y);
        e = '0;
        case (o)
            3'd0: begin e.r[0] = !an && (okey(x) == okey(y)); e.nv = sn; end
            3'd1: begin e.r[0] = !an && (okey(x) <  okey(y)); e.nv = an; end
            3'd2: begin e.r[0] = !an && (okey(x) <= okey(y)); e.nv = an; end
            3'd3, 3'd4: begin
                e.nv = sn;
                if (is_nan(x) && is_nan(y)) e.r = 32'h7FC00000;
                else if (is_nan(x))         e.r = y;
                else if (is_nan(y))         e.r = x;
                else if (o == 3'd3)         e.r = (tkey(x) <= tkey(y)) ? x : y;
                else                        e.r = (tkey(x) >= tkey(y)) ? x : y;
            end
            default: e.ill = 1'b1;
        endcase
        return e;
    endfunction

    function automatic logic [31:0] rnd_val();
        logic s;
        s = 1'($urandom_range(0, 1));
        case ($urandom_range(0, 9))
            0: return {s, 31'd0};
            1: return {s, 8'hFF, 1'b1, 22'($urandom)};
            2: return {s, 8'hFF, 1'b0, 22'($urandom_range(1, 4194303))};
            3: return {s, 8'hFF, 23'd0};
            4: return {s, 8'h00, 23'($urandom)};
            5: return {s, 8'h80, 23'($urandom_range(0, 3))};
            default: return 32'($urandom);
        endcase
    endfunction

    // Monitor: in_ready model, hold-while-stalled, in-order scoreboard
    logic        stall_p = 1'b0;
    logic [31:0] held_r;
    logic        held_nv, held_ill;

    always @(negedge clk) begin
        if (rst) begin
            stall_p = 1'b0;
        end else begin
            chk("in_ready", 32'(in_ready), 32'(!(exp_q.size() == 2 && !out_ready)));
            if (stall_p) begin
                chk("hold_data", cmpdata_out, held_r);
                chk("hold_nv", 32'(nv_flag), 32'(held_nv));
                chk("hold_ill", 32'(illegal_op), 32'(held_ill));
            end
            if (out_valid && out_ready) begin
                chk("result_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    chk("result", cmpdata_out, mon_e.r);
                    chk("nv_flag", 32'(nv_flag), 32'(mon_e.nv));
                    chk("illegal_op", 32'(illegal_op), 32'(mon_e.ill));
                end
            end
            stall_p  = out_valid && !out_ready;
            held_r   = cmpdata_out;
            held_nv  = nv_flag;
            held_ill = illegal_op;
            if (in_valid && in_ready) exp_q.push_back(cur_exp);
        end
    end

    task automatic drive(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, input exp_t e);
        op = o; a = x; b = y; cur_exp = e; in_valid = 1'b1;
    endtask

    // Waits for the current operand to be taken; rel lifts a stall so random runs cannot lock
    task automatic wait_acc(input bit rel);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            if (rel) begin
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
            @(negedge clk);
            n++;
        end
        chk("accept_timeout", 32'(n < 50), 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] er, input logic env, input logic eill);
        exp_t e;
        e.r = er; e.nv = env; e.ill = eill;
        drive(o, x, y, e);
        wait_acc(1'b0);
    endtask

    task automatic half_op(input logic [2:0] o, input logic [15:0] x, input logic [15:0] y,
                           input logic [15:0] er, input logic env);
        h_op = o; h_a = x; h_b = y; h_in_valid = 1'b1;
        #1 chk("h_in_ready", 32'(h_in_ready), 32'd1);
        @(posedge clk);
        #1 h_in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("h_out_valid", 32'(h_out_valid), 32'd1);
        chk("h_result", 32'(h_out), 32'(er));
        chk("h_nv", 32'(h_nv), 32'(env));
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            @(posedge clk);
            n++;
        end
        #1 chk("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    typedef struct packed {
        logic [2:0]  o;
        logic [31:0] x, y, r;
        logic        nv, ill;
    } vec_t;

    localparam int NV = 11;
    vec_t vecs [NV] = '{
        '{3'd1, 32'hC1433333, 32'h41600000, 32'h1,        1'b0, 1'b0},
        '{3'd2, 32'h42000000, 32'h42000000, 32'h1,        1'b0, 1'b0},
        '{3'd0, 32'h00000000, 32'h80000000, 32'h1,        1'b0, 1'b0},
        '{3'd3, 32'h00000000, 32'h80000000, 32'h80000000, 1'b0, 1'b0},
        '{3'd4, 32'h00000000, 32'h80000000, 32'h00000000, 1'b0, 1'b0},
        '{3'd4, 32'h42680000, 32'h42680000, 32'h42680000, 1'b0, 1'b0},
        '{3'd1, 32'h7FC00000, 32'h3F800000, 32'h0,        1'b1, 1'b0},
        '{3'd0, 32'h7FC00000, 32'h3F800000, 32'h0,        1'b0, 1'b0},
        '{3'd4, 32'h7FA00000, 32'h42F00000, 32'h42F00000, 1'b1, 1'b0},
        '{3'd3, 32'h7FC00000, 32'h7FC00000, 32'h7FC00000, 1'b0, 1'b0},
        '{3'd7, 32'h3F800000, 32'h40000000, 32'h0,        1'b0, 1'b1}
    };

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [2:0]  ro;
        logic [31:0] ra, rb;
        in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; op = '0; cur_exp = '0;
        h_in_valid = 1'b0; h_out_ready = 1'b1; h_a = '0; h_b = '0; h_op = '0;

        // Reset state
        #1 rst = 1'b1;
        #2;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_data", cmpdata_out, 32'd0);
        chk("rst_nv", 32'(nv_flag), 32'd0);
        chk("rst_ill", 32'(illegal_op), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 rst = 1'b0; out_ready = 1'b1;
        @(posedge clk);
        #1;

        // Two-cycle latency on an idle pipe
        drive(3'd1, 32'h40200000, 32'h40200000, '{32'h0, 1'b0, 1'b0});
        @(negedge clk);
        chk("lat_0", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        chk("lat_1", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk("lat_2", 32'(out_valid), 32'd1);
        @(posedge clk);
        #1;

        // Directed vectors, back-to-back
        for (int i = 0; i < NV; i++)
            send(vecs[i].o, vecs[i].x, vecs[i].y, vecs[i].r, vecs[i].nv, vecs[i].ill);
        in_valid = 1'b0;
        drain();

        // Backpressure mid-stream: three stalled cycles with both stages full
        send(3'd1, 32'hC0966666, 32'hC093851F, 32'h1, 1'b0, 1'b0);
        send(3'd1, 32'h42000000, 32'h42000106, 32'h1, 1'b0, 1'b0);
        out_ready = 1'b0;
        drive(3'd1, 32'h43160000, 32'hC3340000, '{32'h0, 1'b0, 1'b0});
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
        wait_acc(1'b0);
        in_valid = 1'b0;
        drain();

        // Asynchronous reset with two operations in flight
        out_ready = 1'b0;
        send(3'd0, 32'h3F800000, 32'h3F800000, 32'h1, 1'b0, 1'b0);
        send(3'd7, 32'h3F800000, 32'h3F800000, 32'h0, 1'b0, 1'b1);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_data", cmpdata_out, 32'd0);
        chk("arst_nv", 32'(nv_flag), 32'd0);
        chk("arst_ill", 32'(illegal_op), 32'd0);
        chk("arst_in_ready", 32'(in_ready), 32'd1);
        exp_q.delete();
        @(posedge clk);
        #1 rst = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("no_stale", 32'(out_valid), 32'd0);
        end
        @(posedge clk);
        #1;

        // Random traffic with random consumer stalls
        for (int i = 0; i < 400; i++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0) begin
                in_valid = 1'b0;
                @(posedge clk);
                #1;
            end
            ro = ($urandom_range(0, 19) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
            ra = rnd_val();
            case ($urandom_range(0, 7))
                0, 1:    rb = ra;
                2:       rb = ra ^ 32'h80000000;
                3:       rb = ra + 32'd1;
                default: rb = rnd_val();
            endcase
            drive(ro, ra, rb, model(ro, ra, rb));
            wait_acc(1'b1);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        drain();

        // Half-precision instance
        half_op(3'd1, 16'hC100, 16'h4100, 16'h0001, 1'b0);
        half_op(3'd4, 16'h7E00, 16'h3C00, 16'h3C00, 1'b0);
        half_op(3'd3, 16'h7D00, 16'h7E00, 16'h7E00, 1'b1);
        half_op(3'd0, 16'h8000, 16'h0000, 16'h0001, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fp_cmp_pipe.md
Name: fp_cmp_pipe

Overview:
- Parametrised, pipelined floating-point compare and min/max unit. It is the successor to the combinational single-op less-than block in the ALU module set.
- Executes FEQ, FLT, FLE, FMIN and FMAX with IEEE-754/RISC-V-F semantics on a configurable exponent/mantissa format.
- Connects through valid/ready handshakes on both sides. Sits in the FP execute stage beside the other ALU modules and raises an invalid-operation flag.

Parameters:
- EXP_W, 8, exponent field width in bits.
- MAN_W, 23, mantissa (fraction) field width in bits.
- W, 1+EXP_W+MAN_W, derived operand/result width; not overridden.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- in_valid  input  1  operands and op are valid this cycle.
- in_ready  output  1  unit accepts input this cycle.
- read_data1  input  W  operand A (sign|exp|man).
- read_data2  input  W  operand B.
- op  input  3  000 FEQ, 001 FLT, 010 FLE, 011 FMIN, 100 FMAX, others illegal.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- cmpdata_out  output  W  result.
- nv_flag  output  1  invalid-operation exception flag for this result.
- illegal_op  output  1  op code was unsupported.

Behaviour:
- Reset: asynchronous; all stage valids, out_valid, cmpdata_out, nv_flag and illegal_op clear to 0 immediately. In-flight operations are discarded, not completed. in_ready is 1 during reset release.
- Pipeline: two register stages. A transfer occurs when in_valid&&in_ready.
  - S1 registers the classification: isNaN, isSNaN, isZero, sign, an unsigned magnitude compare of {exp,man} (A<B, A==B), op and both operands.
  - S2 registers the final result and flags.
  - Latency is exactly 2 cycles with no stall: accept at edge N, out_valid at edge N+2.
- Flow control:
  - S2 advances when !out_valid || out_ready.
  - S1 advances into S2 when S2 advances.
  - in_ready = !s1_valid || s2_advance, i.e. fully combinational backpressure with no bubbles.
  - Throughput is 1 op/cycle while out_ready=1.
  - While out_valid && !out_ready, cmpdata_out, nv_flag and illegal_op are held stable.
- Classification:
  - NaN: exp all-ones and man != 0.
  - sNaN: NaN with man MSB = 0.
  - Zero: exp = 0 and man = 0.
  - Subnormals are compared exactly as bit patterns; no flush.
- Ordering:
  - Signs differ: the negative operand is less, unless both are zero, in which case they are equal for compare ops.
  - Both positive: magnitude order.
  - Both negative: inverted magnitude order.
- FEQ/FLT/FLE:
  - Result is {W-1 zeros, bit}.
  - Any NaN operand gives result 0.
  - FEQ sets nv_flag only if either operand is sNaN.
  - FLT/FLE set nv_flag if either operand is any NaN.
- FMIN/FMAX:
  - Both NaN: result is canonical qNaN {0, all-ones exp, 1, zeros}.
  - One NaN: result is the other operand.
  - -0 is treated as less than +0, so FMIN(+0,-0) = -0 and FMAX(+0,-0) = +0.
  - nv_flag is set if either operand is sNaN.
- Illegal op: result 0, nv_flag 0, illegal_op 1, same latency.
- Simultaneous events: a new input accepted on the same edge that S2 drains is legal and required.
- Reset mid-stall: clears regardless of out_ready.

Test Plan:
- FLT 2.5 vs 2.5 (0x40200000, 0x40200000) -> 0 after 2 cycles.
- FLT -12.2 vs 14 (0xC1433333, 0x41600000) -> 1.
- FLE 32 vs 32 -> 1.
- FEQ +0 vs -0 (0x00000000, 0x80000000) -> 1, nv 0.
- FMIN +0/-0 -> 0x80000000.
- FMAX 58 vs 58 -> 0x42680000.
- NaN handling:
  - FLT qNaN 0x7FC00000 vs 1.0 -> 0, nv 1.
  - FEQ same operands -> 0, nv 0.
  - FMAX sNaN 0x7FA00000 vs 120 (0x42F00000) -> 0x42F00000, nv 1.
  - FMIN qNaN vs qNaN -> 0x7FC00000.
- Backpressure:
  - Stream FLT -4.7/-4.61 (0xC0966666, 0xC093851F) -> 1, then 32/32.001 (0x42000000, 0x42000106) -> 1, then 150/-180 -> 0, with out_ready low for 3 cycles mid-stream.
  - Results arrive in order, outputs are stable while stalled, in_ready drops only when both stages are full, and there are no losses or duplicates.
- Reset and illegal op:
  - Assert rst asynchronously between edges with 2 ops in flight: outputs clear immediately, and no stale result appears after release.
  - op=111 -> result 0, illegal_op 1.
  - Re-run with EXP_W=5, MAN_W=10 (half precision): FLT 0xC100 (-2.5) vs 0x4100 -> 1.
